// File: rtl/gray_tracker.sv
// gray_tracker: resynchronizes a Gray-coded count from another clock domain,
// converts it to binary and classifies each change as +1, -1 or an illegal jump.
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous, active-high reset
//   g_in     Gray-coded count, asynchronous to clk
//   err_clr  clears the sticky fault (only acted on while faulted)
//   b        registered binary value of the synchronized count
//   step_up  one-cycle pulse on a +1 step
//   step_dn  one-cycle pulse on a -1 step
//   fault    sticky illegal-jump flag
//   laps     signed-direction wrap counter, modulo 256
module gray_tracker #(
   parameter int bit_size = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [bit_size-1:0] g_in,
   input  logic                err_clr,
   output logic [bit_size-1:0] b,
   output logic                step_up,
   output logic                step_dn,
   output logic                fault,
   output logic [7:0]          laps
);

   localparam logic [bit_size-1:0] ONES = '1;
   localparam logic [bit_size-1:0] ZERO = '0;
   localparam logic [bit_size-1:0] ONE  = bit_size'(1);

   typedef enum logic [1:0] {
      S_INIT,
      S_TRACK,
      S_FAULT
   } state_t;

   state_t              state;
   logic [1:0]          fill;
   logic [bit_size-1:0] s1;
   logic [bit_size-1:0] s2;
   logic [bit_size-1:0] bin_c;
   logic [bit_size-1:0] d;

   // Each binary bit is the XOR of all Gray bits at or above it,
   // i.e. the unrolled form of bin[i] = bin[i+1] ^ gray[i].
   for (genvar i = 0; i < bit_size; i++) begin : g_dec
      assign bin_c[i] = ^s2[bit_size-1:i];
   end

   assign d = bin_c - b;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= g_in;
         s2 <= s1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_INIT;
         fill    <= 2'd0;
         b       <= '0;
         step_up <= 1'b0;
         step_dn <= 1'b0;
         fault   <= 1'b0;
         laps    <= 8'd0;
      end else begin
         step_up <= 1'b0;
         step_dn <= 1'b0;
         case (state)
            S_INIT: begin
               // Two edges to fill s1/s2, the third loads b silently.
               if (fill == 2'd2) begin
                  b     <= bin_c;
                  state <= S_TRACK;
               end else begin
                  fill <= fill + 2'd1;
               end
            end
            S_TRACK: begin
               b <= bin_c;
               if (d == ZERO) begin
                  // unchanged
               end else if (d == ONE) begin
                  step_up <= 1'b1;
                  if (b == ONES && bin_c == ZERO)
                     laps <= laps + 8'd1;
               end else if (d == ONES) begin
                  step_dn <= 1'b1;
                  if (b == ZERO && bin_c == ONES)
                     laps <= laps - 8'd1;
               end else begin
                  // err_clr is deliberately not looked at here, so a jump
                  // coinciding with a clear still latches the fault.
                  fault <= 1'b1;
                  state <= S_FAULT;
               end
            end
            S_FAULT: begin
               b <= bin_c;
               if (err_clr) begin
                  fault <= 1'b0;
                  state <= S_TRACK;
               end
            end
            default: begin
               state <= S_INIT;
               fill  <= 2'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gray_tracker.sv
// tb_gray_tracker: directed scoreboard bench for gray_tracker (bit_size = 3).
// Stimulus pushes hand-computed expected outputs; a monitor pops and compares.
module tb_gray_tracker;

   typedef struct packed {
      logic [2:0] b;
      logic       up;
      logic       dn;
      logic       f;
      logic [7:0] laps;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] g_in = 3'b010;
   logic       err_clr = 1'b0;
   logic [2:0] b;
   logic       step_up;
   logic       step_dn;
   logic       fault;
   logic [7:0] laps;

   exp_t       q[$];
   exp_t       e;
   int         pass_cnt = 0;
   int         total = 0;
   event       mon_ev;

   logic [2:0] gray [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                            3'b110, 3'b111, 3'b101, 3'b100};

   gray_tracker #(.bit_size(3)) dut (
      .clk     (clk),
      .reset   (reset),
      .g_in    (g_in),
      .err_clr (err_clr),
      .b       (b),
      .step_up (step_up),
      .step_dn (step_dn),
      .fault   (fault),
      .laps    (laps)
   );

   always #5 clk = ~clk;

   always @(negedge clk) ->mon_ev;

   initial begin
      forever begin
         @(mon_ev);
         if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if ({b, step_up, step_dn, fault, laps} !==
                {e.b, e.up, e.dn, e.f, e.laps})
               $display("FAIL chk%0d @%0t: got b=%0d up=%b dn=%b fault=%b laps=%0d, want b=%0d up=%b dn=%b fault=%b laps=%0d",
                        total, $time, b, step_up, step_dn, fault, laps,
                        e.b, e.up, e.dn, e.f, e.laps);
            else
               pass_cnt++;
         end
      end
   end

   task automatic push(input logic [2:0] eb, input logic eu, input logic ed,
                       input logic ef, input logic [7:0] el);
      exp_t x;
      x.b = eb; x.up = eu; x.dn = ed; x.f = ef; x.laps = el;
      q.push_back(x);
   endtask

   // Drive inputs, expect given outputs just after the next rising edge.
   task automatic tick(input logic r, input logic [2:0] g, input logic c,
                       input logic [2:0] eb, input logic eu, input logic ed,
                       input logic ef, input logic [7:0] el);
      reset = r; g_in = g; err_clr = c;
      push(eb, eu, ed, ef, el);
      @(posedge clk); #1;
   endtask

   // Hold g for two edges; outputs reflect the value held before this call.
   task automatic step(input logic [2:0] g, input logic [2:0] eb,
                       input logic eu, input logic ed, input logic ef,
                       input logic [7:0] el);
      tick(1'b0, g, 1'b0, eb, eu, ed, ef, el);
      tick(1'b0, g, 1'b0, eb, 1'b0, 1'b0, ef, el);
   endtask

   // Assert reset between edges and sample before the next edge.
   task automatic async_rst(input logic [2:0] g);
      @(negedge clk); #1;
      reset = 1'b1; g_in = g; err_clr = 1'b0;
      #1;
      push(3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
      ->mon_ev;
      push(3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: run did not finish");
      $fatal(1);
   end

   initial begin
      // reset state, g_in = 010 held
      tick(1'b1, 3'b010, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
      tick(1'b1, 3'b010, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
      // init load: edges 1,2 keep 0, edge 3 loads 3
      tick(1'b0, 3'b010, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
      tick(1'b0, 3'b010, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
      tick(1'b0, 3'b010, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 8'd0);
      // single step up 010 -> 110
      step(3'b110, 3'd3, 1'b0, 1'b0, 1'b0, 8'd0);
      step(3'b010, 3'd4, 1'b1, 1'b0, 1'b0, 8'd0);
      // step down to 0, then backward wrap
      step(3'b011, 3'd3, 1'b0, 1'b1, 1'b0, 8'd0);
      step(3'b001, 3'd2, 1'b0, 1'b1, 1'b0, 8'd0);
      step(3'b000, 3'd1, 1'b0, 1'b1, 1'b0, 8'd0);
      step(3'b100, 3'd0, 1'b0, 1'b1, 1'b0, 8'd0);
      step(3'b000, 3'd7, 1'b0, 1'b1, 1'b0, 8'd255);
      // 255 -> 0 wrap, then one full forward revolution
      step(3'b001, 3'd0, 1'b1, 1'b0, 1'b0, 8'd0);
      step(3'b011, 3'd1, 1'b1, 1'b0, 1'b0, 8'd0);
      step(3'b010, 3'd2, 1'b1, 1'b0, 1'b0, 8'd0);
      step(3'b110, 3'd3, 1'b1, 1'b0, 1'b0, 8'd0);
      step(3'b111, 3'd4, 1'b1, 1'b0, 1'b0, 8'd0);
      step(3'b101, 3'd5, 1'b1, 1'b0, 1'b0, 8'd0);
      step(3'b100, 3'd6, 1'b1, 1'b0, 1'b0, 8'd0);
      step(3'b000, 3'd7, 1'b1, 1'b0, 1'b0, 8'd0);
      step(3'b000, 3'd0, 1'b1, 1'b0, 1'b0, 8'd1);
      // illegal jump 0 -> 3, then steps while faulted (incl. a down wrap)
      step(3'b010, 3'd0, 1'b0, 1'b0, 1'b0, 8'd1);
      step(3'b011, 3'd3, 1'b0, 1'b0, 1'b1, 8'd1);
      step(3'b001, 3'd2, 1'b0, 1'b0, 1'b1, 8'd1);
      step(3'b000, 3'd1, 1'b0, 1'b0, 1'b1, 8'd1);
      step(3'b100, 3'd0, 1'b0, 1'b0, 1'b1, 8'd1);
      step(3'b100, 3'd7, 1'b0, 1'b0, 1'b1, 8'd1);
      // clear, then a step pulses again (7 -> 0 wraps laps to 2)
      tick(1'b0, 3'b100, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 8'd1);
      step(3'b000, 3'd7, 1'b0, 1'b0, 1'b0, 8'd1);
      step(3'b001, 3'd0, 1'b1, 1'b0, 1'b0, 8'd2);
      // three more revolutions: laps 2 -> 5
      for (int i = 2; i < 26; i++)
         step(gray[i % 8], 3'((i - 1) % 8), 1'b1, 1'b0, 1'b0,
              8'(2 + (i - 1) / 8));
      // jump 1 -> 3 with err_clr on the same edge: fault still set
      step(3'b010, 3'd1, 1'b1, 1'b0, 1'b0, 8'd5);
      tick(1'b0, 3'b010, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 8'd5);
      tick(1'b0, 3'b010, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 8'd5);
      // async reset with fault = 1, laps = 5
      async_rst(3'b110);
      tick(1'b0, 3'b110, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
      tick(1'b0, 3'b110, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
      tick(1'b0, 3'b110, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 8'd0);
      step(3'b111, 3'd4, 1'b0, 1'b0, 1'b0, 8'd0);
      step(3'b111, 3'd5, 1'b1, 1'b0, 1'b0, 8'd0);
      // drain the scoreboard with a bound
      for (int i = 0; i < 8 && q.size() != 0; i++) @(negedge clk);
      #1;
      if (q.size() != 0) begin
         $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
         total += q.size();
      end
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
